// File: rtl/tcp_misc_pkg.sv
// Shared TCP scheduler types: flag commands, flag-state RAM word and the
// flag scanner's FSM states.
package tcp_misc_pkg;

  localparam int unsigned TIMESTAMP_W = 8;

  typedef enum logic [1:0] {
    CmdSet   = 2'd0,
    CmdClear = 2'd1,
    CmdNop   = 2'd2
  } sched_flag_cmd_e;

  typedef struct packed {
    sched_flag_cmd_e        cmd;
    logic [TIMESTAMP_W-1:0] timestamp;
  } sched_flag_cmd_struct;

  typedef struct packed {
    logic                   flag;
    logic [TIMESTAMP_W-1:0] timestamp;
  } sched_flag_data_struct;

  typedef enum logic [1:0] {
    StReadReq,
    StWaitResp,
    StNotify,
    StClear
  } sched_scan_state_e;

endpackage

// File: rtl/sched_flag_scanner.sv
// Round-robin walker over the per-flow flag RAM: notifies the TX scheduler of
// each set flag, then clears it with the timestamp it observed.
module sched_flag_scanner #(
  parameter int unsigned FLOWID_W    = 4,
  parameter int unsigned TIMESTAMP_W = tcp_misc_pkg::TIMESTAMP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scan_en,
  output logic                     flag_rd_req_val,
  output logic [FLOWID_W-1:0]      flag_rd_req_addr,
  input  logic                     flag_rd_req_rdy,
  input  logic                     flag_rd_resp_val,
  input  logic [TIMESTAMP_W:0]     flag_rd_resp_data,
  output logic                     flag_rd_resp_rdy,
  output logic                     sched_val,
  output logic [FLOWID_W-1:0]      sched_flowid,
  input  logic                     sched_rdy,
  output logic                     flag_cmd_val,
  output logic [FLOWID_W-1:0]      flag_cmd_flowid,
  output logic [TIMESTAMP_W+1:0]   flag_cmd,
  input  logic                     flag_cmd_rdy,
  output logic [31:0]              sched_count
);
  import tcp_misc_pkg::*;

  sched_scan_state_e      state_q, state_d;
  logic [FLOWID_W-1:0]    ptr_q, ptr_d;
  logic [TIMESTAMP_W-1:0] ts_q, ts_d;
  logic [31:0]            count_q, count_d;

  sched_flag_data_struct  resp_data;
  sched_flag_cmd_struct   cmd_s;

  assign resp_data = sched_flag_data_struct'(flag_rd_resp_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReadReq;
      ptr_q   <= '0;
      ts_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ts_q    <= ts_d;
      count_q <= count_d;
    end
  end

  // The pointer only advances when a flow is fully done, so it doubles as the
  // captured flow id for the notify and clear phases.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    ts_d             = ts_q;
    count_d          = count_q;
    flag_rd_req_val  = 1'b0;
    flag_rd_resp_rdy = 1'b0;
    sched_val        = 1'b0;
    flag_cmd_val     = 1'b0;
    cmd_s.cmd        = CmdNop;
    cmd_s.timestamp  = '0;

    unique case (state_q)
      StReadReq: begin
        flag_rd_req_val = scan_en;
        if (scan_en && flag_rd_req_rdy) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        flag_rd_resp_rdy = 1'b1;
        if (flag_rd_resp_val) begin
          ts_d = resp_data.timestamp;
          if (resp_data.flag) begin
            state_d = StNotify;
          end else begin
            ptr_d   = ptr_q + FLOWID_W'(1);
            state_d = StReadReq;
          end
        end
      end
      StNotify: begin
        sched_val = 1'b1;
        if (sched_rdy) begin
          if (count_q != '1) begin
            count_d = count_q + 32'd1;
          end
          state_d = StClear;
        end
      end
      StClear: begin
        flag_cmd_val    = 1'b1;
        cmd_s.cmd       = CmdClear;
        cmd_s.timestamp = ts_q;
        if (flag_cmd_rdy) begin
          ptr_d   = ptr_q + FLOWID_W'(1);
          state_d = StReadReq;
        end
      end
      default: state_d = StReadReq;
    endcase
  end

  assign flag_rd_req_addr = ptr_q;
  assign sched_flowid     = ptr_q;
  assign flag_cmd_flowid  = ptr_q;
  assign flag_cmd         = cmd_s;
  assign sched_count      = count_q;

endmodule

// File: tb/tb_sched_flag_scanner.sv
// Directed bench for sched_flag_scanner with a single-cycle flag RAM model and
// a flag updater that drops stale CLEARs.
module tb_sched_flag_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        flag_rd_req_val;
  logic [3:0]  flag_rd_req_addr;
  logic        flag_rd_req_rdy;
  logic        flag_rd_resp_val;
  logic [8:0]  flag_rd_resp_data;
  logic        flag_rd_resp_rdy;
  logic        sched_val;
  logic [3:0]  sched_flowid;
  logic        sched_rdy;
  logic        flag_cmd_val;
  logic [3:0]  flag_cmd_flowid;
  logic [9:0]  flag_cmd;
  logic        flag_cmd_rdy;
  logic [31:0] sched_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic       ram_flag [16];
  logic [7:0] ram_ts   [16];

  int rd_log[$];
  int sched_log[$];
  int cmd_fid_log[$];
  int cmd_ts_log[$];
  int cmd_code_log[$];

  always #5 clk = ~clk;

  sched_flag_scanner #(
    .FLOWID_W    (4),
    .TIMESTAMP_W (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .scan_en           (scan_en),
    .flag_rd_req_val   (flag_rd_req_val),
    .flag_rd_req_addr  (flag_rd_req_addr),
    .flag_rd_req_rdy   (flag_rd_req_rdy),
    .flag_rd_resp_val  (flag_rd_resp_val),
    .flag_rd_resp_data (flag_rd_resp_data),
    .flag_rd_resp_rdy  (flag_rd_resp_rdy),
    .sched_val         (sched_val),
    .sched_flowid      (sched_flowid),
    .sched_rdy         (sched_rdy),
    .flag_cmd_val      (flag_cmd_val),
    .flag_cmd_flowid   (flag_cmd_flowid),
    .flag_cmd          (flag_cmd),
    .flag_cmd_rdy      (flag_cmd_rdy),
    .sched_count       (sched_count)
  );

  // Single-cycle RAM read port sharing rst with the scanner.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_rd_resp_val  <= 1'b0;
      flag_rd_resp_data <= '0;
    end else if (flag_rd_req_val && flag_rd_req_rdy) begin
      flag_rd_resp_val  <= 1'b1;
      flag_rd_resp_data <= {ram_flag[flag_rd_req_addr], ram_ts[flag_rd_req_addr]};
    end else if (flag_rd_resp_val && flag_rd_resp_rdy) begin
      flag_rd_resp_val <= 1'b0;
    end
  end

  // Updater: a CLEAR only takes effect if its timestamp is not older.
  always @(posedge clk) begin
    if (!rst && flag_cmd_val && flag_cmd_rdy && flag_cmd[9:8] == 2'b01 &&
        flag_cmd[7:0] >= ram_ts[flag_cmd_flowid]) begin
      ram_flag[flag_cmd_flowid] <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (flag_rd_req_val && flag_rd_req_rdy) rd_log.push_back(int'(flag_rd_req_addr));
      if (sched_val && sched_rdy) sched_log.push_back(int'(sched_flowid));
      if (flag_cmd_val && flag_cmd_rdy) begin
        cmd_fid_log.push_back(int'(flag_cmd_flowid));
        cmd_ts_log.push_back(int'(flag_cmd[7:0]));
        cmd_code_log.push_back(int'(flag_cmd[9:8]));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scan_en = 1'b1;
    sched_rdy = 1'b1;
    flag_cmd_rdy = 1'b1;
    flag_rd_req_rdy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      ram_flag[i] = 1'b0;
      ram_ts[i]   = 8'd0;
    end
    rd_log.delete();
    sched_log.delete();
    cmd_fid_log.delete();
    cmd_ts_log.delete();
    cmd_code_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_rd(input int n, input string tag);
    int c = 0;
    while (rd_log.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(rd_log.size() >= n), 32'd1);
  endtask

  task automatic wait_cmd(input int n, input string tag);
    int c = 0;
    while (cmd_fid_log.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(cmd_fid_log.size() >= n), 32'd1);
  endtask

  task automatic wait_sched_val(input string tag);
    int c = 0;
    while (!sched_val && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(sched_val), 32'd1);
  endtask

  initial begin
    int n0;
    int stable;

    // Reset state
    rst = 1'b1;
    scan_en = 1'b0;
    sched_rdy = 1'b1;
    flag_cmd_rdy = 1'b1;
    flag_rd_req_rdy = 1'b1;
    #3;
    check("rst_req_val", 32'(flag_rd_req_val), 32'd0);
    check("rst_resp_rdy", 32'(flag_rd_resp_rdy), 32'd0);
    check("rst_sched_val", 32'(sched_val), 32'd0);
    check("rst_cmd_val", 32'(flag_cmd_val), 32'd0);
    check("rst_cmd_nop", 32'(flag_cmd[9:8]), 32'd2);
    check("rst_count", sched_count, 32'd0);

    // All flags clear: plain walk 0..15, 0
    do_reset();
    wait_rd(17, "walk_timeout");
    for (int i = 0; i < 17; i++) check($sformatf("walk_addr%0d", i), 32'(rd_log[i]), 32'(i % 16));
    check("walk_no_sched", 32'(sched_log.size()), 32'd0);
    check("walk_no_cmd", 32'(cmd_fid_log.size()), 32'd0);

    // Flow 5 set with ts 3
    do_reset();
    ram_flag[5] = 1'b1;
    ram_ts[5]   = 8'd3;
    wait_cmd(1, "f5_cmd_timeout");
    wait_rd(7, "f5_rd_timeout");
    check("f5_sched_fid", 32'(sched_log[0]), 32'd5);
    check("f5_cmd_fid", 32'(cmd_fid_log[0]), 32'd5);
    check("f5_cmd_code", 32'(cmd_code_log[0]), 32'd1);
    check("f5_cmd_ts", 32'(cmd_ts_log[0]), 32'd3);
    check("f5_count", sched_count, 32'd1);
    check("f5_next_addr", 32'(rd_log[6]), 32'd6);
    check("f5_flag_cleared", 32'(ram_flag[5]), 32'd0);

    // SET races the stalled notify: stale clear is dropped, flow re-notified
    do_reset();
    ram_flag[5] = 1'b1;
    ram_ts[5]   = 8'd3;
    sched_rdy   = 1'b0;
    wait_sched_val("race_sched_timeout");
    ram_ts[5]   = 8'd4;
    sched_rdy   = 1'b1;
    wait_cmd(1, "race_cmd1_timeout");
    @(negedge clk);
    check("race_cmd1_ts", 32'(cmd_ts_log[0]), 32'd3);
    check("race_flag_kept", 32'(ram_flag[5]), 32'd1);
    wait_cmd(2, "race_cmd2_timeout");
    @(negedge clk);
    check("race_cmd2_fid", 32'(cmd_fid_log[1]), 32'd5);
    check("race_cmd2_ts", 32'(cmd_ts_log[1]), 32'd4);
    check("race_count", sched_count, 32'd2);
    check("race_flag_cleared", 32'(ram_flag[5]), 32'd0);

    // Flow 15 under scheduler backpressure, then wrap to 0
    do_reset();
    ram_flag[15] = 1'b1;
    ram_ts[15]   = 8'd7;
    sched_rdy    = 1'b0;
    wait_sched_val("bp_sched_timeout");
    n0 = rd_log.size();
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sched_val && sched_flowid == 4'd15 && !flag_rd_req_val) stable++;
    end
    check("bp_stable", 32'(stable), 32'd10);
    check("bp_no_reads", 32'(rd_log.size()), 32'(n0));
    check("bp_last_addr", 32'(rd_log[n0-1]), 32'd15);
    sched_rdy = 1'b1;
    wait_cmd(1, "bp_cmd_timeout");
    wait_rd(n0 + 1, "bp_rd_timeout");
    check("bp_wrap_addr", 32'(rd_log[n0]), 32'd0);

    // scan_en dropped during notify of flow 2
    do_reset();
    ram_flag[2] = 1'b1;
    ram_ts[2]   = 8'd9;
    sched_rdy   = 1'b0;
    wait_sched_val("en_sched_timeout");
    scan_en   = 1'b0;
    sched_rdy = 1'b1;
    wait_cmd(1, "en_cmd_timeout");
    repeat (10) @(negedge clk);
    check("en_cmd_ts", 32'(cmd_ts_log[0]), 32'd9);
    check("en_idle_reads", 32'(rd_log.size()), 32'd3);
    check("en_idle_req", 32'(flag_rd_req_val), 32'd0);
    scan_en = 1'b1;
    wait_rd(4, "en_rd_timeout");
    check("en_resume_addr", 32'(rd_log[3]), 32'd3);

    // Asynchronous reset while in CLEAR
    do_reset();
    ram_flag[3]  = 1'b1;
    ram_ts[3]    = 8'd1;
    flag_cmd_rdy = 1'b0;
    begin
      int c = 0;
      while (!flag_cmd_val && c < 300) begin
        @(negedge clk);
        c++;
      end
      check("ar_cmd_val", 32'(flag_cmd_val), 32'd1);
    end
    check("ar_pre_count", sched_count, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_cmd_val_low", 32'(flag_cmd_val), 32'd0);
    check("ar_cmd_nop", 32'(flag_cmd[9:8]), 32'd2);
    check("ar_sched_val_low", 32'(sched_val), 32'd0);
    check("ar_count_zero", sched_count, 32'd0);
    do_reset();
    wait_rd(1, "ar_rd_timeout");
    check("ar_first_addr", 32'(rd_log[0]), 32'd0);
    check("ar_post_count", sched_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
